// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: tear-free pending/display registers, per-digit slot timing.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking of digits 1..DIGITS-1.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS           = 4,
    parameter int unsigned DIV              = 50000,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic [DIGITS-1:0]     in_dp,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  blank,
    output logic [3:0]            hex,
    output logic                  dp,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_start
);

    localparam int unsigned       CNT_W     = $clog2(DIV);
    localparam int unsigned       IDX_W     = $clog2(DIGITS);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{ANODE_ACTIVE_LOW}};

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_disp_data;
    logic [DIGITS-1:0]   r_disp_dp;
    logic [4*DIGITS-1:0] r_pend_data;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pend_full;
    logic                r_wrap;
    logic [3:0]          r_hex;
    logic                r_dp;
    logic [DIGITS-1:0]   r_anode;
    logic                r_frame_start;

    logic                w_tick;
    logic                w_boundary;
    logic                w_accept;
    logic                w_commit;
    logic [DIGITS-1:0]   w_show;
    logic [DIGITS-1:0]   w_onehot;
    logic [3:0]          w_hex;
    logic                w_dp_sel;
    logic [DIGITS-1:0]   w_anode_d;
    logic                w_dp_d;

    assign w_tick     = (r_cnt == CNT_MAX);
    assign w_boundary = w_tick && (r_idx == IDX_MAX);
    assign w_accept   = in_valid && !r_pend_full;
    assign w_commit   = w_boundary && r_pend_full;

`ifdef SEG_SCAN_LZB_EN
    // Digit k is visible if any nibble from k upward is nonzero; digit 0 always visible.
    assign w_show[0] = 1'b1;
    for (genvar k = 1; k < DIGITS; k++) begin : g_lzb
        assign w_show[k] = |r_disp_data[4*DIGITS-1:4*k];
    end
`else
    assign w_show = '1;
`endif

    always_comb begin
        w_hex    = 4'h0;
        w_dp_sel = 1'b0;
        w_onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_hex       = r_disp_data[4*k +: 4];
                w_dp_sel    = r_disp_dp[k] & w_show[k];
                w_onehot[k] = w_show[k];
            end
        end
        if (blank) begin
            w_anode_d = ANODE_OFF;
        end else begin
            w_anode_d = ANODE_ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
        w_dp_d = !blank && w_dp_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_disp_data   <= '0;
            r_disp_dp     <= '0;
            r_pend_data   <= '0;
            r_pend_dp     <= '0;
            r_pend_full   <= 1'b0;
            r_wrap        <= 1'b0;
            r_hex         <= 4'h0;
            r_dp          <= 1'b0;
            r_anode       <= ANODE_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end
            if (w_accept) begin
                r_pend_data <= in_data;
                r_pend_dp   <= in_dp;
            end
            // Accept and commit are mutually exclusive: commit needs pend_full, accept needs it clear.
            if (w_commit) begin
                r_disp_data <= r_pend_data;
                r_disp_dp   <= r_pend_dp;
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend_full <= 1'b1;
            end
            r_wrap        <= w_boundary;
            r_frame_start <= r_wrap;
            r_hex         <= w_hex;
            r_dp          <= w_dp_d;
            r_anode       <= w_anode_d;
        end
    end

    assign in_ready    = !r_pend_full;
    assign hex         = r_hex;
    assign dp          = r_dp;
    assign anode       = r_anode;
    assign frame_start = r_frame_start;

endmodule
